// File: rtl/axi4_fpu_job_slave.sv
// AXI4 slave front-end that queues two-beat operand writes as FPU jobs and returns results on reads.
// Optional macro FPU_AXI_SLVERR_EN: SLVERR on bad writes and on results carrying the error flag.
module axi4_fpu_job_slave #(
  parameter int unsigned ID_W  = 4,
  parameter int unsigned DEPTH = 4
) (
  input  logic                   ACLK,
  input  logic                   ARESETn,
  input  logic [ID_W-1:0]        AWID,
  input  logic [11:0]            AWADDR,
  input  logic [7:0]             AWLEN,
  input  logic [2:0]             AWSIZE,
  input  logic [1:0]             AWBURST,
  input  logic                   AWVALID,
  output logic                   AWREADY,
  input  logic [31:0]            WDATA,
  input  logic [3:0]             WSTRB,
  input  logic                   WLAST,
  input  logic                   WVALID,
  output logic                   WREADY,
  output logic [ID_W-1:0]        BID,
  output logic [1:0]             BRESP,
  output logic                   BVALID,
  input  logic                   BREADY,
  input  logic [ID_W-1:0]        ARID,
  input  logic [11:0]            ARADDR,
  input  logic [7:0]             ARLEN,
  input  logic                   ARVALID,
  output logic                   ARREADY,
  output logic [ID_W-1:0]        RID,
  output logic [31:0]            RDATA,
  output logic [1:0]             RRESP,
  output logic                   RLAST,
  output logic                   RVALID,
  input  logic                   RREADY,
  output logic                   fpu_req_valid,
  output logic [1:0]             fpu_op,
  output logic [31:0]            fpu_a,
  output logic [31:0]            fpu_b,
  input  logic                   fpu_rsp_valid,
  input  logic [31:0]            fpu_rsp_data,
  input  logic                   fpu_rsp_err,
  output logic [$clog2(DEPTH):0] job_count,
  output logic [$clog2(DEPTH):0] res_count
);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef struct packed {
    logic [ID_W-1:0] id;
    logic [1:0]      op;
    logic [31:0]     a;
    logic [31:0]     b;
    logic            bad;
  } job_t;

  typedef struct packed {
    logic [ID_W-1:0] id;
    logic [31:0]     data;
    logic            err;
  } res_t;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
  typedef enum logic       {D_IDLE, D_BUSY} d_state_t;
  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_DATA} r_state_t;

  w_state_t w_state;
  d_state_t d_state;
  r_state_t r_state;

  job_t job_mem [DEPTH];
  res_t res_mem [DEPTH];
  logic [PW-1:0] job_wr, job_rd, res_wr, res_rd;

  logic [ID_W-1:0] w_id, d_id;
  logic [7:0]      w_opc, w_len, w_beat;
  logic [31:0]     w_a, w_b, a_c, b_c;
  logic            w_bad_c, job_push_c, job_pop_c, res_push_c, res_pop_c, d_take_c, rsp_err_c;
  logic [1:0]      bresp_c, rresp_c;
  job_t            job_in_c, job_head;
  res_t            res_in_c, res_head;
  logic            unused_c;

  // Assembled job as it stands on the WLAST beat.
  assign a_c        = (w_beat == 8'd0) ? WDATA : w_a;
  assign b_c        = (w_beat == 8'd1) ? WDATA : w_b;
  assign w_bad_c    = (w_opc > 8'd2) || (w_len != 8'd1) || (w_beat != w_len);
  assign job_push_c = (w_state == W_DATA) && WVALID && WREADY && WLAST;
  assign job_in_c   = '{id: w_id, op: w_opc[1:0], a: a_c, b: b_c, bad: w_bad_c};
  assign job_head   = job_mem[job_rd];
  assign res_head   = res_mem[res_rd];

  assign d_take_c   = (d_state == D_IDLE) && (job_count != '0) && (res_count != FULL);
  assign job_pop_c  = d_take_c;
  assign res_push_c = (d_take_c && job_head.bad) || ((d_state == D_BUSY) && fpu_rsp_valid);
  assign res_in_c   = (d_state == D_BUSY) ? '{id: d_id, data: fpu_rsp_data, err: rsp_err_c}
                                          : '{id: job_head.id, data: 32'd0, err: 1'b1};
  assign res_pop_c  = (r_state == R_DATA) && RVALID && RREADY;

`ifdef FPU_AXI_SLVERR_EN
  assign bresp_c   = w_bad_c ? 2'd2 : 2'd0;
  assign rresp_c   = res_head.err ? 2'd2 : 2'd0;
  assign rsp_err_c = fpu_rsp_err;
  assign unused_c  = ^{AWSIZE, AWBURST, AWADDR[11:8], WSTRB, ARADDR, ARLEN, res_head.id};
`else
  assign bresp_c   = 2'd0;
  assign rresp_c   = 2'd0;
  assign rsp_err_c = 1'b0;
  assign unused_c  = ^{AWSIZE, AWBURST, AWADDR[11:8], WSTRB, ARADDR, ARLEN, res_head.id,
                       res_head.err, fpu_rsp_err};
`endif

  // Write FSM: AW, operand beats, B response.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      w_state <= W_IDLE;
      AWREADY <= 1'b0;
      WREADY  <= 1'b0;
      BVALID  <= 1'b0;
      BID     <= '0;
      BRESP   <= 2'd0;
      w_id    <= '0;
      w_opc   <= '0;
      w_len   <= '0;
      w_beat  <= '0;
      w_a     <= '0;
      w_b     <= '0;
    end else begin
      case (w_state)
        W_IDLE: begin
          if (AWVALID && AWREADY) begin
            w_id    <= AWID;
            w_opc   <= AWADDR[7:0];
            w_len   <= AWLEN;
            w_beat  <= '0;
            w_a     <= '0;
            w_b     <= '0;
            AWREADY <= 1'b0;
            WREADY  <= 1'b1;
            w_state <= W_DATA;
          end else begin
            AWREADY <= (job_count != FULL);
          end
        end
        W_DATA: begin
          if (WVALID && WREADY) begin
            w_a <= a_c;
            w_b <= b_c;
            if (w_beat != 8'hFF) w_beat <= w_beat + 8'd1;
            if (WLAST) begin
              WREADY  <= 1'b0;
              BVALID  <= 1'b1;
              BID     <= w_id;
              BRESP   <= bresp_c;
              w_state <= W_RESP;
            end
          end
        end
        W_RESP: begin
          if (BREADY) begin
            BVALID  <= 1'b0;
            AWREADY <= (job_count != FULL);
            w_state <= W_IDLE;
          end
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

  // Dispatcher: one FPU job in flight; bad jobs short-circuit to an error result.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      d_state       <= D_IDLE;
      d_id          <= '0;
      fpu_req_valid <= 1'b0;
      fpu_op        <= 2'd0;
      fpu_a         <= '0;
      fpu_b         <= '0;
    end else begin
      fpu_req_valid <= 1'b0;
      case (d_state)
        D_IDLE: begin
          if (d_take_c && !job_head.bad) begin
            fpu_req_valid <= 1'b1;
            fpu_op        <= job_head.op;
            fpu_a         <= job_head.a;
            fpu_b         <= job_head.b;
            d_id          <= job_head.id;
            d_state       <= D_BUSY;
          end
        end
        D_BUSY: if (fpu_rsp_valid) d_state <= D_IDLE;
        default: d_state <= D_IDLE;
      endcase
    end
  end

  // Read FSM: AR, wait for a result, single-beat R.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      r_state <= R_IDLE;
      ARREADY <= 1'b0;
      RVALID  <= 1'b0;
      RLAST   <= 1'b0;
      RID     <= '0;
      RDATA   <= '0;
      RRESP   <= 2'd0;
    end else begin
      case (r_state)
        R_IDLE: begin
          if (ARVALID && ARREADY) begin
            RID     <= ARID;
            ARREADY <= 1'b0;
            r_state <= R_WAIT;
          end else begin
            ARREADY <= 1'b1;
          end
        end
        R_WAIT: begin
          if (res_count != '0) begin
            RVALID  <= 1'b1;
            RLAST   <= 1'b1;
            RDATA   <= res_head.data;
            RRESP   <= rresp_c;
            r_state <= R_DATA;
          end
        end
        R_DATA: begin
          if (RREADY) begin
            RVALID  <= 1'b0;
            RLAST   <= 1'b0;
            ARREADY <= 1'b1;
            r_state <= R_IDLE;
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      job_wr    <= '0;
      job_rd    <= '0;
      res_wr    <= '0;
      res_rd    <= '0;
      job_count <= '0;
      res_count <= '0;
    end else begin
      if (job_push_c) job_wr <= job_wr + PW'(1);
      if (job_pop_c)  job_rd <= job_rd + PW'(1);
      if (res_push_c) res_wr <= res_wr + PW'(1);
      if (res_pop_c)  res_rd <= res_rd + PW'(1);
      job_count <= job_count + CW'(job_push_c) - CW'(job_pop_c);
      res_count <= res_count + CW'(res_push_c) - CW'(res_pop_c);
    end
  end

  // FIFO storage needs no reset; occupancy gates every read.
  always_ff @(posedge ACLK) begin
    if (job_push_c) job_mem[job_wr] <= job_in_c;
    if (res_push_c) res_mem[res_wr] <= res_in_c;
  end
endmodule

// File: tb/tb_axi4_fpu_job_slave.sv
// Bench for axi4_fpu_job_slave: directed AXI transactions, FPU responder model, result scoreboard.
module tb_axi4_fpu_job_slave;
  localparam int unsigned ID_W  = 4;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned CW    = $clog2(DEPTH) + 1;

  logic ACLK = 1'b0;
  logic ARESETn;
  logic [ID_W-1:0] AWID, BID, ARID, RID;
  logic [11:0] AWADDR, ARADDR;
  logic [7:0] AWLEN, ARLEN;
  logic [2:0] AWSIZE;
  logic [1:0] AWBURST, BRESP, RRESP, fpu_op;
  logic [31:0] WDATA, RDATA, fpu_a, fpu_b, fpu_rsp_data;
  logic [3:0] WSTRB;
  logic AWVALID, AWREADY, WLAST, WVALID, WREADY, BVALID, BREADY, ARVALID, ARREADY;
  logic RLAST, RVALID, RREADY, fpu_req_valid, fpu_rsp_valid, fpu_rsp_err;
  logic [CW-1:0] job_count, res_count;

  axi4_fpu_job_slave #(.ID_W(ID_W), .DEPTH(DEPTH)) dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
    .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
    .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY),
    .fpu_req_valid(fpu_req_valid), .fpu_op(fpu_op), .fpu_a(fpu_a), .fpu_b(fpu_b),
    .fpu_rsp_valid(fpu_rsp_valid), .fpu_rsp_data(fpu_rsp_data), .fpu_rsp_err(fpu_rsp_err),
    .job_count(job_count), .res_count(res_count)
  );

  always #5 ACLK = ~ACLK;

  typedef struct packed { logic [31:0] data; logic [1:0] resp; } exp_t;
  typedef struct packed { logic [1:0] op; logic [31:0] a; logic [31:0] b; } iss_t;

  exp_t sb_q[$];
  iss_t iss_q[$];
  int tests = 0;
  int fails = 0;
  int req_cnt = 0;
  int rc;
  bit fpu_en = 1'b1;
  logic pend = 1'b0;
  logic [1:0] p_op;
  logic [31:0] p_a, p_b;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference behaviour of the external FPU as seen by this bench.
  function automatic logic [31:0] fpu_fn(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    if (op == 2'd0 && a == 32'h4040_0000 && b == 32'h4080_0000) return 32'h40E0_0000;
    return a ^ {b[30:0], 1'b0} ^ {30'd0, op};
  endfunction

  task automatic axi_write(input logic [ID_W-1:0] id, input logic [11:0] addr, input logic [7:0] len,
                           input int nbeats, input logic [31:0] a, input logic [31:0] b);
    logic bad;
    logic [1:0] op, exp_b;
    exp_t e;
    int t;
    op  = addr[1:0];
    bad = (addr[7:0] > 8'd2) || (len != 8'd1) || (8'(nbeats - 1) != len);
    e.data = bad ? 32'd0 : fpu_fn(op, a, b);
`ifdef FPU_AXI_SLVERR_EN
    e.resp = (bad || (op == 2'd2 && b == 32'd0)) ? 2'd2 : 2'd0;
    exp_b  = bad ? 2'd2 : 2'd0;
`else
    e.resp = 2'd0;
    exp_b  = 2'd0;
`endif
    sb_q.push_back(e);
    if (!bad) iss_q.push_back(iss_t'{op: op, a: a, b: b});
    @(negedge ACLK);
    AWVALID = 1'b1; AWID = id; AWADDR = addr; AWLEN = len; AWSIZE = 3'd2; AWBURST = 2'd1;
    t = 0;
    while (!AWREADY && t < 200) begin @(negedge ACLK); t++; end
    chk("aw_handshake", 64'(t < 200), 64'(1));
    @(negedge ACLK);
    AWVALID = 1'b0;
    for (int i = 0; i < nbeats; i++) begin
      WVALID = 1'b1;
      WDATA  = (i == 0) ? a : (i == 1) ? b : $urandom;
      WSTRB  = 4'(i);
      WLAST  = (i == nbeats - 1);
      t = 0;
      while (!WREADY && t < 50) begin @(negedge ACLK); t++; end
      @(negedge ACLK);
    end
    WVALID = 1'b0; WLAST = 1'b0;
    BREADY = 1'b1;
    t = 0;
    while (!BVALID && t < 50) begin @(negedge ACLK); t++; end
    chk("b_valid", 64'(BVALID), 64'(1));
    chk("b_id", 64'(BID), 64'(id));
    chk("b_resp", 64'(BRESP), 64'(exp_b));
    @(negedge ACLK);
    BREADY = 1'b0;
  endtask

  task automatic ar_issue(input logic [ID_W-1:0] id);
    int t;
    @(negedge ACLK);
    ARVALID = 1'b1; ARID = id; ARADDR = 12'($urandom); ARLEN = 8'($urandom);
    t = 0;
    while (!ARREADY && t < 50) begin @(negedge ACLK); t++; end
    chk("ar_handshake", 64'(t < 50), 64'(1));
    @(negedge ACLK);
    ARVALID = 1'b0;
  endtask

  task automatic r_collect(input logic [ID_W-1:0] id);
    exp_t e;
    int t;
    RREADY = 1'b1;
    t = 0;
    while (!RVALID && t < 300) begin @(negedge ACLK); t++; end
    chk("r_valid", 64'(RVALID), 64'(1));
    chk("sb_nonempty", 64'(sb_q.size() > 0), 64'(1));
    e = (sb_q.size() > 0) ? sb_q.pop_front() : '0;
    chk("r_id", 64'(RID), 64'(id));
    chk("r_data", 64'(RDATA), 64'(e.data));
    chk("r_resp", 64'(RRESP), 64'(e.resp));
    chk("r_last", 64'(RLAST), 64'(1));
    @(negedge ACLK);
    RREADY = 1'b0;
  endtask

  // FPU responder: checks each issued job and answers one cycle later while enabled.
  initial begin
    iss_t it;
    fpu_rsp_valid = 1'b0; fpu_rsp_data = '0; fpu_rsp_err = 1'b0;
    forever begin
      @(negedge ACLK);
      fpu_rsp_valid = 1'b0;
      if (!ARESETn) begin
        pend = 1'b0;
      end else if (fpu_req_valid) begin
        req_cnt++;
        chk("fpu_expected_req", 64'(iss_q.size() > 0), 64'(1));
        it = (iss_q.size() > 0) ? iss_q.pop_front() : '0;
        chk("fpu_op", 64'(fpu_op), 64'(it.op));
        chk("fpu_a", 64'(fpu_a), 64'(it.a));
        chk("fpu_b", 64'(fpu_b), 64'(it.b));
        p_op = it.op; p_a = it.a; p_b = it.b;
        pend = 1'b1;
      end else if (pend && fpu_en) begin
        fpu_rsp_valid = 1'b1;
        fpu_rsp_data  = fpu_fn(p_op, p_a, p_b);
        fpu_rsp_err   = (p_op == 2'd2 && p_b == 32'd0);
        pend = 1'b0;
      end
    end
  end

  initial begin
    int t;
    ARESETn = 1'b0;
    AWVALID = 0; AWID = '0; AWADDR = '0; AWLEN = '0; AWSIZE = '0; AWBURST = '0;
    WVALID = 0; WDATA = '0; WSTRB = '0; WLAST = 0; BREADY = 0;
    ARVALID = 0; ARID = '0; ARADDR = '0; ARLEN = '0; RREADY = 0;
    repeat (3) @(negedge ACLK);
    chk("rst_handshakes", 64'({AWREADY, WREADY, ARREADY, BVALID, RVALID, RLAST, fpu_req_valid}), 64'(0));
    chk("rst_data", 64'({BID, BRESP, RID, RRESP, RDATA}), 64'(0));
    chk("rst_counts", 64'({job_count, res_count}), 64'(0));
    ARESETn = 1'b1;
    @(negedge ACLK);
    chk("post_rst_ready", 64'({AWREADY, ARREADY}), 64'(2'b11));

    // Add 3.0 + 4.0
    axi_write(4'h3, 12'h000, 8'd1, 2, 32'h4040_0000, 32'h4080_0000);
    repeat (6) @(negedge ACLK);
    chk("add_req_pulses", 64'(req_cnt), 64'(1));
    chk("add_res_count", 64'(res_count), 64'(1));
    ar_issue(4'h5);
    r_collect(4'h5);

    // Bad opcode and bad length never reach the FPU
    rc = req_cnt;
    axi_write(4'h6, 12'h005, 8'd1, 2, 32'h1234_5678, 32'h9ABC_DEF0);
    axi_write(4'h1, 12'h000, 8'd0, 1, 32'h3F80_0000, 32'd0);
    repeat (6) @(negedge ACLK);
    chk("bad_no_req", 64'(req_cnt), 64'(rc));
    ar_issue(4'h7);
    r_collect(4'h7);
    ar_issue(4'h8);
    r_collect(4'h8);

    // Divide by zero
    axi_write(4'h2, 12'h002, 8'd1, 2, 32'h3F80_0000, 32'd0);
    ar_issue(4'h9);
    r_collect(4'h9);

    // Early read waits for a result and returns ARID
    ar_issue(4'hA);
    repeat (10) @(negedge ACLK);
    chk("early_rvalid_low", 64'(RVALID), 64'(0));
    axi_write(4'h4, 12'h001, 8'd1, 2, 32'h4000_0000, 32'h4040_0000);
    r_collect(4'hA);

    // Backpressure: FPU stalls, job FIFO fills
    fpu_en = 1'b0;
    rc = req_cnt;
    for (int i = 0; i < 5; i++)
      axi_write(4'(i), 12'h001, 8'd1, 2, 32'h1000_0000 + 32'(i), 32'h2000_0000 + 32'(i));
    repeat (5) @(negedge ACLK);
    chk("bp_job_count", 64'(job_count), 64'(DEPTH));
    chk("bp_awready_low", 64'(AWREADY), 64'(0));
    chk("bp_one_issued", 64'(req_cnt), 64'(rc + 1));
    fpu_en = 1'b1;
    axi_write(4'h5, 12'h000, 8'd1, 2, 32'h1000_0005, 32'h2000_0005);
    repeat (30) @(negedge ACLK);
    chk("bp_res_full", 64'(res_count), 64'(DEPTH));
    chk("bp_jobs_left", 64'(job_count), 64'(2));
    for (int i = 0; i < 6; i++) begin
      ar_issue(4'(i + 8));
      r_collect(4'(i + 8));
    end

    // Reset after the first data beat
    rc = req_cnt;
    @(negedge ACLK);
    AWVALID = 1'b1; AWID = 4'hC; AWADDR = 12'h000; AWLEN = 8'd1;
    t = 0;
    while (!AWREADY && t < 50) begin @(negedge ACLK); t++; end
    @(negedge ACLK);
    AWVALID = 1'b0; WVALID = 1'b1; WDATA = 32'h4040_0000; WLAST = 1'b0;
    t = 0;
    while (!WREADY && t < 50) begin @(negedge ACLK); t++; end
    @(negedge ACLK);
    WVALID = 1'b0;
    ARESETn = 1'b0;
    #1;
    chk("mid_rst_handshakes", 64'({AWREADY, WREADY, ARREADY, BVALID, RVALID, fpu_req_valid}), 64'(0));
    chk("mid_rst_counts", 64'({job_count, res_count}), 64'(0));
    @(negedge ACLK);
    ARESETn = 1'b1;
    repeat (5) @(negedge ACLK);
    chk("mid_rst_no_job", 64'({job_count, res_count}), 64'(0));
    chk("mid_rst_no_req", 64'(req_cnt), 64'(rc));
    chk("mid_rst_awready", 64'(AWREADY), 64'(1));

    chk("sb_drained", 64'(sb_q.size()), 64'(0));
    chk("iss_drained", 64'(iss_q.size()), 64'(0));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
